// File: rtl/alu_issue_queue_pkg.sv
// Shared types and constants for the ALU issue queue: operand/control widths,
// one-hot ALU op bit positions, the queue entry record and the CDB wakeup helpers.
package alu_iq_pkg;

    localparam int DATA_W = 16;
    localparam int SIG_W  = 12;
    localparam int TAG_W  = 3;

    // Bit positions inside the one-hot alusignals vector.
    localparam int ISADD = 0;
    localparam int ISLD  = 1;
    localparam int ISST  = 2;
    localparam int ISSUB = 3;
    localparam int ISMUL = 4;
    localparam int ISCMP = 5;
    localparam int ISMOV = 6;
    localparam int ISOR  = 7;
    localparam int ISAND = 8;
    localparam int ISNOT = 9;
    localparam int ISLSL = 10;
    localparam int ISLSR = 11;

    typedef struct packed {
        logic              valid;
        logic [SIG_W-1:0]  signals;
        logic [4:0]        immx;
        logic              isimm;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  src1_tag;
        logic              src1_rdy;
        logic [DATA_W-1:0] src1_val;
        logic [TAG_W-1:0]  src2_tag;
        logic              src2_rdy;
        logic [DATA_W-1:0] src2_val;
    } iq_entry_t;

    // One-hot control word with only the given op bit set.
    function automatic logic [SIG_W-1:0] sig_of(input int idx);
        return SIG_W'(1) << idx;
    endfunction

    // True when a still-waiting source is satisfied by the broadcast this cycle.
    function automatic logic cdb_match(input logic rdy, input logic [TAG_W-1:0] tag,
                                       input logic cdb_valid, input logic [TAG_W-1:0] cdb_tag);
        return !rdy && cdb_valid && (tag == cdb_tag);
    endfunction

    // Entry as it will look after latching any matching broadcast.
    function automatic iq_entry_t wake_entry(input iq_entry_t e, input logic cdb_valid,
                                             input logic [TAG_W-1:0] cdb_tag,
                                             input logic [DATA_W-1:0] cdb_value);
        iq_entry_t r;
        r = e;
        if (e.valid && cdb_match(e.src1_rdy, e.src1_tag, cdb_valid, cdb_tag)) begin
            r.src1_rdy = 1'b1;
            r.src1_val = cdb_value;
        end
        if (e.valid && cdb_match(e.src2_rdy, e.src2_tag, cdb_valid, cdb_tag)) begin
            r.src2_rdy = 1'b1;
            r.src2_val = cdb_value;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Bundle of the issue queue's enqueue, result-bus and issue signals.
// master = the pipeline around the queue, slave = the queue itself.
interface alu_iq_if #(parameter int DEPTH = 4);
    import alu_iq_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Enqueue side (decoded op from rename/dispatch)
    logic              in_valid;
    logic              in_ready;
    logic [SIG_W-1:0]  in_alusignals;
    logic [4:0]        in_immx;
    logic              in_isimmediate;
    logic [TAG_W-1:0]  in_dest_tag;
    logic [TAG_W-1:0]  in_src1_tag;
    logic [TAG_W-1:0]  in_src2_tag;
    logic              in_src1_rdy;
    logic              in_src2_rdy;
    logic [DATA_W-1:0] in_src1_val;
    logic [DATA_W-1:0] in_src2_val;

    // Common result bus
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;

    // Issue side (towards the ALU)
    logic              iss_valid;
    logic [SIG_W-1:0]  iss_alusignals;
    logic [DATA_W-1:0] iss_op1;
    logic [DATA_W-1:0] iss_op2;
    logic [4:0]        iss_immx;
    logic              iss_isimmediate;
    logic [TAG_W-1:0]  iss_dest_tag;

    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_alusignals, in_immx, in_isimmediate, in_dest_tag,
               in_src1_tag, in_src2_tag, in_src1_rdy, in_src2_rdy, in_src1_val, in_src2_val,
               cdb_valid, cdb_tag, cdb_value,
        input  in_ready, iss_valid, iss_alusignals, iss_op1, iss_op2, iss_immx,
               iss_isimmediate, iss_dest_tag, count
    );

    modport slave (
        input  in_valid, in_alusignals, in_immx, in_isimmediate, in_dest_tag,
               in_src1_tag, in_src2_tag, in_src1_rdy, in_src2_rdy, in_src1_val, in_src2_val,
               cdb_valid, cdb_tag, cdb_value,
        output in_ready, iss_valid, iss_alusignals, iss_op1, iss_op2, iss_immx,
               iss_isimmediate, iss_dest_tag, count
    );

endinterface

// File: rtl/alu_issue_queue_select.sv
// Oldest-first picker: reports whether any entry is eligible and the lowest
// such index (index 0 is always the oldest entry in the collapsing queue).
module alu_iq_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] eligible,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the youngest down so the oldest eligible entry wins last.
    always_comb begin
        // NOTE: every output gets a default before the scan; a path that leaves one unassigned infers a latch.
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: collapsing, age-ordered reservation queue that holds decoded
// ALU ops until both operands are present and issues the oldest ready op each
// cycle into registered iss_* outputs. Operands wake up from the result bus.
// Operand/control widths come from alu_iq_pkg; DEPTH is the only parameter.
// Optional macro IQ_WAKEUP_SELECT_EN: select also treats a source matching the
// same-cycle broadcast as ready and forwards that value into iss_op1/iss_op2.
module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    alu_iq_if.slave   bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    iq_entry_t         entries      [DEPTH];
    iq_entry_t         next_entries [DEPTH];
    iq_entry_t         woke         [DEPTH+1];
    iq_entry_t         enq_entry;
    iq_entry_t         sel_entry;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  tail;
    logic              enq;

    logic [DEPTH-1:0]  eligible;
    logic              src1_ok      [DEPTH];
    logic              src2_ok      [DEPTH];
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;

    logic              iss_valid;
    logic [SIG_W-1:0]  iss_alusignals;
    logic [DATA_W-1:0] iss_op1;
    logic [DATA_W-1:0] iss_op2;
    logic [4:0]        iss_immx;
    logic              iss_isimmediate;
    logic [TAG_W-1:0]  iss_dest_tag;

    // Acceptance depends only on the registered occupancy, never on a same-cycle issue.
    assign bus.in_ready = (count != CNT_W'(DEPTH));
    assign enq          = bus.in_valid && bus.in_ready;

    // Operand readiness seen by select, and the eligibility vector.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < DEPTH; i++) begin
            src1_ok[i] = entries[i].src1_rdy;
            src2_ok[i] = entries[i].src2_rdy;
`ifdef IQ_WAKEUP_SELECT_EN
            src1_ok[i] = src1_ok[i] ||
                         cdb_match(entries[i].src1_rdy, entries[i].src1_tag, bus.cdb_valid, bus.cdb_tag);
            src2_ok[i] = src2_ok[i] ||
                         cdb_match(entries[i].src2_rdy, entries[i].src2_tag, bus.cdb_valid, bus.cdb_tag);
`endif
            eligible[i] = entries[i].valid && src1_ok[i] && src2_ok[i];
        end
    end

    alu_iq_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .eligible (eligible),
        .found    (sel_found),
        .idx      (sel_idx)
    );

    // Read out the chosen entry and its operand values (with broadcast forwarding when enabled).
    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_entry = entries[i];
            end
        end
        sel_op1 = sel_entry.src1_val;
        sel_op2 = sel_entry.src2_val;
`ifdef IQ_WAKEUP_SELECT_EN
        // A selected entry with a non-ready source can only have been selected via the broadcast.
        if (!sel_entry.src1_rdy) begin
            sel_op1 = bus.cdb_value;
        end
        if (!sel_entry.src2_rdy) begin
            sel_op2 = bus.cdb_value;
        end
`endif
    end

    // Incoming op with immediate handling and same-cycle broadcast bypass.
    always_comb begin
        enq_entry          = '0;
        enq_entry.valid    = 1'b1;
        enq_entry.signals  = bus.in_alusignals;
        enq_entry.immx     = bus.in_immx;
        enq_entry.isimm    = bus.in_isimmediate;
        enq_entry.dest     = bus.in_dest_tag;
        enq_entry.src1_tag = bus.in_src1_tag;
        enq_entry.src1_rdy = bus.in_src1_rdy;
        enq_entry.src1_val = bus.in_src1_val;
        enq_entry.src2_tag = bus.in_src2_tag;
        enq_entry.src2_rdy = bus.in_src2_rdy || bus.in_isimmediate;
        enq_entry.src2_val = bus.in_src2_val;
        enq_entry          = wake_entry(enq_entry, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end

    // Wakeup, collapse above the issued slot, then append the new op at the post-collapse tail.
    always_comb begin
        woke[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = wake_entry(entries[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        end
        tail = count - CNT_W'(sel_found);
        for (int i = 0; i < DEPTH; i++) begin
            next_entries[i] = (sel_found && (i >= int'(sel_idx))) ? woke[i+1] : woke[i];
            if (enq && (CNT_W'(i) == tail)) begin
                next_entries[i] = enq_entry;
            end
        end
        count_next = count + CNT_W'(enq) - CNT_W'(sel_found);
    end

    // Queue state, occupancy and issue registers; reset and flush clear everything.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset || flush) begin
            // NOTE: the entry array is small and its valid bits must clear, so the whole array is reset here.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            count           <= '0;
            iss_valid       <= 1'b0;
            iss_alusignals  <= '0;
            iss_op1         <= '0;
            iss_op2         <= '0;
            iss_immx        <= '0;
            iss_isimmediate <= 1'b0;
            iss_dest_tag    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= next_entries[i];
            end
            count     <= count_next;
            iss_valid <= sel_found;
            if (sel_found) begin
                iss_alusignals  <= sel_entry.signals;
                iss_op1         <= sel_op1;
                iss_op2         <= sel_op2;
                iss_immx        <= sel_entry.immx;
                iss_isimmediate <= sel_entry.isimm;
                iss_dest_tag    <= sel_entry.dest;
            end
        end
    end

    assign bus.iss_valid       = iss_valid;
    assign bus.iss_alusignals  = iss_alusignals;
    assign bus.iss_op1         = iss_op1;
    assign bus.iss_op2         = iss_op2;
    assign bus.iss_immx        = iss_immx;
    assign bus.iss_isimmediate = iss_isimmediate;
    assign bus.iss_dest_tag    = iss_dest_tag;
    assign bus.count           = count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue (default build, IQ_WAKEUP_SELECT_EN undefined).
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_alu_issue_queue;
    import alu_iq_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    alu_iq_if #(.DEPTH(DEPTH)) bus ();

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid       = 1'b0;
        bus.in_alusignals  = '0;
        bus.in_immx        = '0;
        bus.in_isimmediate = 1'b0;
        bus.in_dest_tag    = '0;
        bus.in_src1_tag    = '0;
        bus.in_src2_tag    = '0;
        bus.in_src1_rdy    = 1'b0;
        bus.in_src2_rdy    = 1'b0;
        bus.in_src1_val    = '0;
        bus.in_src2_val    = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_value      = '0;
    endtask

    task automatic set_op(input int op, input logic [TAG_W-1:0] dest,
                          input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                          input logic r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
        bus.in_valid       = 1'b1;
        bus.in_alusignals  = sig_of(op);
        bus.in_immx        = '0;
        bus.in_isimmediate = 1'b0;
        bus.in_dest_tag    = dest;
        bus.in_src1_rdy    = r1;
        bus.in_src1_tag    = t1;
        bus.in_src1_val    = v1;
        bus.in_src2_rdy    = r2;
        bus.in_src2_tag    = t2;
        bus.in_src2_val    = v2;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] value);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_value = value;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        reset = 1'b1;
        flush = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_count", 32'(bus.count), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_iss_valid", 32'(bus.iss_valid), 0);
        check("rst_iss_op1", 32'(bus.iss_op1), 0);
        check("rst_iss_sig", 32'(bus.iss_alusignals), 0);

        // ADD with both operands ready
        set_op(ISADD, 3'd1, 1'b1, 3'd0, 16'h0005, 1'b1, 3'd0, 16'h0003);
        step();
        idle();
        check("add_enq_count", 32'(bus.count), 1);
        check("add_enq_iss_valid", 32'(bus.iss_valid), 0);
        step();
        check("add_iss_valid", 32'(bus.iss_valid), 1);
        check("add_iss_sig", 32'(bus.iss_alusignals), 32'h001);
        check("add_iss_op1", 32'(bus.iss_op1), 32'h0005);
        check("add_iss_op2", 32'(bus.iss_op2), 32'h0003);
        check("add_iss_dest", 32'(bus.iss_dest_tag), 1);
        check("add_count_back", 32'(bus.count), 0);
        step();
        check("add_idle_valid", 32'(bus.iss_valid), 0);
        check("add_idle_hold_op1", 32'(bus.iss_op1), 32'h0005);

        // SUB waiting on tag 2, woken two cycles later
        set_op(ISSUB, 3'd2, 1'b0, 3'd2, 16'h0000, 1'b1, 3'd0, 16'h0001);
        step();
        idle();
        check("sub_count", 32'(bus.count), 1);
        step();
        check("sub_wait_valid", 32'(bus.iss_valid), 0);
        set_cdb(3'd2, 16'h0010);
        step();
        idle();
        check("sub_wake_cycle_valid", 32'(bus.iss_valid), 0);
        step();
        check("sub_iss_valid", 32'(bus.iss_valid), 1);
        check("sub_iss_sig", 32'(bus.iss_alusignals), 32'h008);
        check("sub_iss_op1", 32'(bus.iss_op1), 32'h0010);
        check("sub_iss_op2", 32'(bus.iss_op2), 32'h0001);
        check("sub_count_back", 32'(bus.count), 0);

        // Fill with four waiting ops: dest0/tag4, dest1/tag5, dest2/tag6, dest3/tag4
        set_op(ISMUL, 3'd0, 1'b0, 3'd4, 16'h0000, 1'b1, 3'd0, 16'h0002);
        step();
        set_op(ISOR, 3'd1, 1'b0, 3'd5, 16'h0000, 1'b1, 3'd0, 16'h0002);
        step();
        set_op(ISAND, 3'd2, 1'b0, 3'd6, 16'h0000, 1'b1, 3'd0, 16'h0002);
        step();
        set_op(ISCMP, 3'd3, 1'b0, 3'd4, 16'h0000, 1'b1, 3'd0, 16'h0002);
        step();
        check("full_count", 32'(bus.count), 4);
        check("full_in_ready", 32'(bus.in_ready), 0);
        // Ready op offered while full must be dropped
        set_op(ISNOT, 3'd7, 1'b1, 3'd0, 16'h00FF, 1'b1, 3'd0, 16'h00FF);
        step();
        check("full_ignore_count", 32'(bus.count), 4);
        check("full_ignore_valid", 32'(bus.iss_valid), 0);
        set_cdb(3'd6, 16'h0066);
        step();
        bus.cdb_valid = 1'b0;
        check("full_wake_count", 32'(bus.count), 4);
        check("full_wake_valid", 32'(bus.iss_valid), 0);
        // Issue while full with in_valid still high: no enqueue that edge
        step();
        idle();
        check("full_iss_valid", 32'(bus.iss_valid), 1);
        check("full_iss_dest", 32'(bus.iss_dest_tag), 2);
        check("full_iss_op1", 32'(bus.iss_op1), 32'h0066);
        check("full_iss_sig", 32'(bus.iss_alusignals), 32'h100);
        check("full_after_count", 32'(bus.count), 3);
        check("full_after_ready", 32'(bus.in_ready), 1);

        // Oldest and youngest wake together; oldest issues first
        set_cdb(3'd4, 16'h0044);
        step();
        idle();
        check("age_wake_valid", 32'(bus.iss_valid), 0);
        check("age_wake_count", 32'(bus.count), 3);
        step();
        check("age_first_valid", 32'(bus.iss_valid), 1);
        check("age_first_dest", 32'(bus.iss_dest_tag), 0);
        check("age_first_op1", 32'(bus.iss_op1), 32'h0044);
        check("age_first_count", 32'(bus.count), 2);
        step();
        check("age_second_valid", 32'(bus.iss_valid), 1);
        check("age_second_dest", 32'(bus.iss_dest_tag), 3);
        check("age_second_sig", 32'(bus.iss_alusignals), 32'h020);
        check("age_second_count", 32'(bus.count), 1);
        step();
        check("age_drain_valid", 32'(bus.iss_valid), 0);
        check("age_drain_count", 32'(bus.count), 1);

        // Immediate op: src2 not ready but satisfied by the immediate
        set_op(ISADD, 3'd5, 1'b1, 3'd0, 16'h0007, 1'b0, 3'd7, 16'h0000);
        bus.in_isimmediate = 1'b1;
        bus.in_immx        = 5'b00011;
        step();
        idle();
        check("imm_count", 32'(bus.count), 2);
        step();
        check("imm_iss_valid", 32'(bus.iss_valid), 1);
        check("imm_iss_dest", 32'(bus.iss_dest_tag), 5);
        check("imm_iss_immx", 32'(bus.iss_immx), 3);
        check("imm_iss_isimm", 32'(bus.iss_isimmediate), 1);
        check("imm_iss_op1", 32'(bus.iss_op1), 32'h0007);
        check("imm_count_back", 32'(bus.count), 1);

        // Enqueue bypass: broadcast matches the source in the enqueue cycle
        set_op(ISMOV, 3'd6, 1'b0, 3'd3, 16'h0000, 1'b1, 3'd0, 16'h0000);
        set_cdb(3'd3, 16'h0033);
        step();
        idle();
        check("byp_count", 32'(bus.count), 2);
        step();
        check("byp_iss_valid", 32'(bus.iss_valid), 1);
        check("byp_iss_dest", 32'(bus.iss_dest_tag), 6);
        check("byp_iss_op1", 32'(bus.iss_op1), 32'h0033);
        check("byp_iss_isimm", 32'(bus.iss_isimmediate), 0);
        check("byp_count_back", 32'(bus.count), 1);

        // Simultaneous enqueue and issue keeps the count
        set_op(ISLSL, 3'd7, 1'b1, 3'd0, 16'h000A, 1'b1, 3'd0, 16'h000B);
        step();
        check("ei_count_a", 32'(bus.count), 2);
        set_op(ISLSR, 3'd4, 1'b1, 3'd0, 16'h000C, 1'b1, 3'd0, 16'h000D);
        step();
        idle();
        check("ei_iss_dest_a", 32'(bus.iss_dest_tag), 7);
        check("ei_iss_op1_a", 32'(bus.iss_op1), 32'h000A);
        check("ei_count_b", 32'(bus.count), 2);
        step();
        check("ei_iss_valid_b", 32'(bus.iss_valid), 1);
        check("ei_iss_dest_b", 32'(bus.iss_dest_tag), 4);
        check("ei_iss_op2_b", 32'(bus.iss_op2), 32'h000D);
        check("ei_iss_sig_b", 32'(bus.iss_alusignals), 32'h800);
        check("ei_count_c", 32'(bus.count), 1);

        // Flush with three pending entries plus an enqueue and a broadcast
        set_op(ISAND, 3'd2, 1'b0, 3'd6, 16'h0000, 1'b1, 3'd0, 16'h0001);
        step();
        set_op(ISOR, 3'd3, 1'b0, 3'd6, 16'h0000, 1'b1, 3'd0, 16'h0001);
        step();
        check("fl_pre_count", 32'(bus.count), 3);
        set_op(ISADD, 3'd1, 1'b1, 3'd0, 16'h0009, 1'b1, 3'd0, 16'h0009);
        set_cdb(3'd5, 16'h0055);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("fl_count", 32'(bus.count), 0);
        check("fl_iss_valid", 32'(bus.iss_valid), 0);
        check("fl_iss_op1", 32'(bus.iss_op1), 0);
        check("fl_iss_sig", 32'(bus.iss_alusignals), 0);
        check("fl_iss_dest", 32'(bus.iss_dest_tag), 0);
        check("fl_in_ready", 32'(bus.in_ready), 1);
        step();
        check("fl_dropped_valid", 32'(bus.iss_valid), 0);
        check("fl_dropped_count", 32'(bus.count), 0);
        step();
        check("fl_quiet_valid", 32'(bus.iss_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
